// File: rtl/rob_multi_pkg.sv
// rob_multi_pkg: shared types and defaults for the multi-port reorder buffer
package rob_multi_pkg;
  localparam int ROB_WIDTH_DEF = 4;
  // CDB tags are carried at a fixed width so the bus type is independent of ROB size
  localparam int TAG_W = 8;
  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } rob_entry;
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } cdb_t;
endpackage

// File: rtl/rob_commit_select.sv
// rob_commit_select: in-order prefix of committable slots and count of retired entries
module rob_commit_select #(
  parameter int N = 2,
  parameter int W = 3
) (
  input  logic [N-1:0] ok,
  input  logic [N-1:0] take,
  output logic [N-1:0] ready,
  output logic [W-1:0] n
);
  always_comb begin
    logic r, f;
    r = 1'b1;
    f = 1'b1;
    n = '0;
    ready = '0;
    for (int k = 0; k < N; k++) begin
      r = r && ok[k];
      f = f && r && take[k];
      ready[k] = r;
      n = n + W'(f);
    end
  end
endmodule

// File: rtl/rob_multi.sv
// rob_multi: reorder buffer with multiple CDB writes, bypassed operand reads and
// up to N_COMMIT in-order retirements per cycle
module rob_multi
  import rob_multi_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEF,
  parameter int N_CDB     = 2,
  parameter int N_READ    = 4,
  parameter int N_COMMIT  = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [N_READ-1:0][ROB_WIDTH-1:0]     read_tag,
  output rob_entry [N_READ-1:0]                read,
  input  cdb_t [N_CDB-1:0]                     cdb,
  input  logic                                 issue,
  output logic                                 issue_ready,
  output logic [ROB_WIDTH-1:0]                 issue_tag,
  input  logic [N_COMMIT-1:0]                  commit_valid,
  output logic [N_COMMIT-1:0]                  commit_ready,
  output logic [N_COMMIT-1:0][ROB_WIDTH-1:0]   commit_tag,
  output logic [N_COMMIT-1:0][31:0]            commit_data,
  input  logic                                 flush,
  output logic [ROB_WIDTH:0]                   count,
  output logic                                 full,
  output logic                                 empty
);
  localparam int DEPTH = 2 ** ROB_WIDTH;
  rob_entry mem [DEPTH];
  logic [ROB_WIDTH-1:0] commit_ptr;
  logic [N_COMMIT-1:0]  ok;
  logic [ROB_WIDTH:0]   n;
  logic                 issue_fire;
  assign full        = count == (ROB_WIDTH+1)'(DEPTH);
  assign empty       = count == '0;
  assign issue_ready = !full;
  assign issue_fire  = issue && !full;
  always_comb begin
    commit_tag  = '0;
    commit_data = '0;
    ok          = '0;
    for (int k = 0; k < N_COMMIT; k++) begin
      commit_tag[k]  = commit_ptr + ROB_WIDTH'(k);
      commit_data[k] = mem[commit_tag[k]].data;
      ok[k]          = ((ROB_WIDTH+1)'(k) < count) && mem[commit_tag[k]].valid;
    end
  end
  // lowest-numbered bus wins because it is applied last
  always_comb begin
    read = '0;
    for (int i = 0; i < N_READ; i++) begin
      read[i] = mem[read_tag[i]];
      for (int j = N_CDB - 1; j >= 0; j--)
        if (cdb[j].valid && cdb[j].tag == TAG_W'(read_tag[i]))
          read[i] = '{valid: 1'b1, data: cdb[j].data};
    end
  end
  rob_commit_select #(.N(N_COMMIT), .W(ROB_WIDTH + 1)) u_sel (
    .ok   (ok),
    .take (commit_valid),
    .ready(commit_ready),
    .n    (n)
  );
  always_ff @(posedge clk)
    if (reset || flush) begin
      issue_tag  <= '0;
      commit_ptr <= '0;
      count      <= '0;
    end else begin
      issue_tag  <= issue_tag + ROB_WIDTH'(issue_fire);
      commit_ptr <= commit_ptr + n[ROB_WIDTH-1:0];
      count      <= count + (ROB_WIDTH+1)'(issue_fire) - n;
    end
  // a completion landing on the slot being allocated overrides the valid clear
  always_ff @(posedge clk)
    if (!reset && !flush)
      for (int e = 0; e < DEPTH; e++) begin
        if (issue_fire && issue_tag == ROB_WIDTH'(e))
          mem[e].valid <= 1'b0;
        for (int j = N_CDB - 1; j >= 0; j--)
          if (cdb[j].valid && cdb[j].tag == TAG_W'(e))
            mem[e] <= '{valid: 1'b1, data: cdb[j].data};
      end
  always_ff @(posedge clk)
    if (!reset)
      for (int j = 0; j < N_CDB; j++)
        for (int k = j + 1; k < N_CDB; k++)
          assert (!(cdb[j].valid && cdb[k].valid && cdb[j].tag == cdb[k].tag));
endmodule

// File: tb/tb_rob_multi.sv
// tb_rob_multi: scenario tasks with a tag scoreboard checking rob_multi commits
module tb_rob_multi;
  import rob_multi_pkg::*;
  logic clk = 1'b0;
  logic reset, issue, flush;
  logic [3:0][1:0] read_tag;
  rob_entry [3:0] read;
  cdb_t [1:0] cdb;
  logic issue_ready, full, empty;
  logic [1:0] issue_tag, commit_valid, commit_ready;
  logic [1:0][1:0] commit_tag;
  logic [1:0][31:0] commit_data;
  logic [2:0] count;
  int m_iptr, m_cptr, m_cnt;
  logic m_valid [4];
  logic [31:0] m_data [4];
  int exp_q [$];
  int checks = 0;
  int errors = 0;

  rob_multi #(.ROB_WIDTH(2), .N_CDB(2), .N_READ(4), .N_COMMIT(2)) dut (
    .clk(clk), .reset(reset), .read_tag(read_tag), .read(read), .cdb(cdb),
    .issue(issue), .issue_ready(issue_ready), .issue_tag(issue_tag),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_tag(commit_tag), .commit_data(commit_data), .flush(flush),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic iss, input logic [1:0] cv, input logic fl);
    logic [1:0] mf, mr;
    logic r, f, ifire;
    int n, t;
    issue = iss;
    commit_valid = cv;
    flush = fl;
    #1;
    r = 1'b1; f = 1'b1; n = 0; mr = '0; mf = '0;
    for (int k = 0; k < 2; k++) begin
      r = r && (k < m_cnt) && m_valid[(m_cptr + k) % 4];
      f = f && r && cv[k];
      mr[k] = r;
      mf[k] = f;
      n += int'(f);
    end
    checks++; if (commit_ready !== mr) begin errors++; $display("FAIL commit_ready: got %b want %b", commit_ready, mr); end
    checks++; if (issue_tag !== 2'(m_iptr)) begin errors++; $display("FAIL issue_tag: got %0d want %0d", issue_tag, m_iptr); end
    checks++; if (count !== 3'(m_cnt)) begin errors++; $display("FAIL count: got %0d want %0d", count, m_cnt); end
    checks++; if (full !== (m_cnt == 4)) begin errors++; $display("FAIL full: got %b want %b", full, m_cnt == 4); end
    checks++; if (empty !== (m_cnt == 0)) begin errors++; $display("FAIL empty: got %b want %b", empty, m_cnt == 0); end
    checks++; if (issue_ready !== (m_cnt != 4)) begin errors++; $display("FAIL issue_ready: got %b want %b", issue_ready, m_cnt != 4); end
    if (!fl)
      for (int k = 0; k < 2; k++)
        if (mf[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL scoreboard_empty: slot %0d fired with nothing expected", k);
          end else begin
            t = exp_q.pop_front();
            if (commit_tag[k] !== 2'(t)) begin errors++; $display("FAIL commit_tag[%0d]: got %0d want %0d", k, commit_tag[k], t); end
            checks++;
            if (commit_data[k] !== m_data[t]) begin errors++; $display("FAIL commit_data[%0d]: got %h want %h", k, commit_data[k], m_data[t]); end
          end
        end
    ifire = iss && (m_cnt < 4);
    @(posedge clk);
    if (fl) begin
      m_iptr = 0; m_cptr = 0; m_cnt = 0;
      exp_q.delete();
    end else begin
      if (ifire) begin
        m_valid[m_iptr] = 1'b0;
        exp_q.push_back(m_iptr);
      end
      for (int j = 1; j >= 0; j--)
        if (cdb[j].valid) begin
          m_valid[cdb[j].tag[1:0]] = 1'b1;
          m_data[cdb[j].tag[1:0]] = cdb[j].data;
        end
      if (ifire) m_iptr = (m_iptr + 1) % 4;
      m_cptr = (m_cptr + n) % 4;
      m_cnt = m_cnt + int'(ifire) - n;
    end
    #1;
    issue = 1'b0; commit_valid = '0; flush = 1'b0; cdb = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1; issue = 1'b0; flush = 1'b0; commit_valid = '0; cdb = '0; read_tag = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_iptr = 0; m_cptr = 0; m_cnt = 0;
    for (int e = 0; e < 4; e++) begin m_valid[e] = 1'b0; m_data[e] = '0; end
    #1;
    checks++; if (issue_tag !== 2'd0) begin errors++; $display("FAIL reset_issue_tag: got %0d want 0", issue_tag); end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty %b full %b want 1 0", empty, full); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (commit_ready !== 2'b00) begin errors++; $display("FAIL reset_commit_ready: got %b want 00", commit_ready); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'b00, 1'b0);
    cyc(1'b0, 2'b00, 1'b0);
  endtask

  task automatic test_complete_commit;
    cdb[0] = '{valid: 1'b1, tag: 8'd1, data: 32'hAA};
    cdb[1] = '{valid: 1'b1, tag: 8'd0, data: 32'h55};
    cyc(1'b0, 2'b00, 1'b0);
    cyc(1'b0, 2'b11, 1'b0);
    cyc(1'b0, 2'b00, 1'b0);
  endtask

  task automatic test_prefix;
    cdb[0] = '{valid: 1'b1, tag: 8'd3, data: 32'h33};
    cyc(1'b0, 2'b00, 1'b0);
    cyc(1'b0, 2'b11, 1'b0);
    cdb[0] = '{valid: 1'b1, tag: 8'd2, data: 32'h22};
    cyc(1'b0, 2'b00, 1'b0);
    cyc(1'b0, 2'b11, 1'b0);
  endtask

  task automatic test_read_bypass;
    read_tag[0] = 2'd3; read_tag[1] = 2'd2; read_tag[2] = 2'd0; read_tag[3] = 2'd1;
    cdb[1] = '{valid: 1'b1, tag: 8'd3, data: 32'h1234};
    #1;
    checks++; if (read[0] !== '{valid: 1'b1, data: 32'h1234}) begin errors++; $display("FAIL read_bypass: got %b/%h want 1/00001234", read[0].valid, read[0].data); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (read[i] !== '{valid: m_valid[read_tag[i]], data: m_data[read_tag[i]]}) begin
        errors++; $display("FAIL read_entry[%0d]: got %b/%h want %b/%h", i, read[i].valid, read[i].data, m_valid[read_tag[i]], m_data[read_tag[i]]);
      end
    end
    cyc(1'b0, 2'b00, 1'b0);
  endtask

  task automatic test_issue_bypass;
    cyc(1'b1, 2'b00, 1'b0);
    cyc(1'b1, 2'b00, 1'b0);
    cdb[0] = '{valid: 1'b1, tag: 8'd2, data: 32'h77};
    cyc(1'b1, 2'b00, 1'b0);
    cdb[0] = '{valid: 1'b1, tag: 8'd0, data: 32'h10};
    cdb[1] = '{valid: 1'b1, tag: 8'd1, data: 32'h11};
    cyc(1'b0, 2'b00, 1'b0);
    cyc(1'b0, 2'b11, 1'b0);
    cyc(1'b0, 2'b01, 1'b0);
  endtask

  task automatic test_wrap;
    cdb[0] = '{valid: 1'b1, tag: 8'(m_iptr), data: 32'h100};
    cyc(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cdb[0] = '{valid: 1'b1, tag: 8'(m_iptr), data: 32'h200 + 32'(i)};
      cyc(1'b1, 2'b01, 1'b0);
    end
  endtask

  task automatic test_flush;
    cyc(1'b1, 2'b00, 1'b0);
    cyc(1'b1, 2'b00, 1'b0);
    cdb[0] = '{valid: 1'b1, tag: 8'(m_iptr), data: 32'hDEAD};
    cyc(1'b1, 2'b01, 1'b1);
    cyc(1'b0, 2'b01, 1'b0);
    cyc(1'b1, 2'b00, 1'b0);
    cyc(1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    test_reset;
    test_fill;
    test_complete_commit;
    test_prefix;
    test_read_bypass;
    test_issue_bypass;
    test_wrap;
    test_flush;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
